// File: rtl/cv32e40p_obi_resp_pkg.sv
// rtl/cv32e40p_obi_resp_pkg.sv - shared types, limits and helpers for the OBI memory responder
package cv32e40p_obi_resp_pkg;

    localparam int OBI_MAX_LAT         = 4;
    localparam int OBI_MAX_OUTSTANDING = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } obi_resp_t;

    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

    function automatic bit params_ok(input int mem_words, input int resp_lat,
                                     input int max_outstanding, input int gnt_stall);
        return (mem_words >= 16) && (mem_words <= 65536) &&
               ((mem_words & (mem_words - 1)) == 0) &&
               (resp_lat >= 1) && (resp_lat <= OBI_MAX_LAT) &&
               (max_outstanding >= 1) && (max_outstanding <= OBI_MAX_OUTSTANDING) &&
               (gnt_stall >= 0) && (gnt_stall <= 7);
    endfunction

endpackage

// File: rtl/cv32e40p_obi_mem_responder_if.sv
// rtl/cv32e40p_obi_mem_responder_if.sv - OBI address/response phase signal bundle
interface cv32e40p_obi_mem_responder_if;

    logic        req;
    logic        gnt;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        parity;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err, parity
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err, parity
    );

endinterface

// File: rtl/cv32e40p_obi_resp_pipe.sv
// rtl/cv32e40p_obi_resp_pipe.sv - fixed-latency response shift register with synchronous clear
module cv32e40p_obi_resp_pipe
    import cv32e40p_obi_resp_pkg::*;
#(
    parameter int RESP_LAT = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_resp_t resp_i,
    output obi_resp_t resp_o
);

    obi_resp_t stage_q [RESP_LAT];
    obi_resp_t stage_d [RESP_LAT];

    always_comb begin
        stage_d[0] = resp_i;
        for (int i = 1; i < RESP_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Whole entries are cleared, not just valids, so outputs read zero after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign resp_o = stage_q[RESP_LAT-1];

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// rtl/cv32e40p_obi_mem_responder.sv - OBI memory responder with SRAM model, latency and back-pressure
module cv32e40p_obi_mem_responder
    import cv32e40p_obi_resp_pkg::*;
#(
    parameter int MEM_WORDS       = 1024,
    parameter int RESP_LAT        = 1,
    parameter int MAX_OUTSTANDING = 2,
    parameter int GNT_STALL       = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    cv32e40p_obi_mem_responder_if.slave   bus,
    output logic [2:0]                    outstanding_o
);

    localparam int AW = $clog2(MEM_WORDS);

    if (!params_ok(MEM_WORDS, RESP_LAT, MAX_OUTSTANDING, GNT_STALL)) begin : g_bad_params
        $error("cv32e40p_obi_mem_responder: parameter out of range");
    end

    logic [2:0]    cnt_q, cnt_d;
    logic [2:0]    stall_q, stall_d;
    logic          accept;
    logic          in_range;
    logic [29:0]   word_idx;
    logic [AW-1:0] mem_idx;
    logic          addr_lsb_unused;
    logic [31:0]   mem_q [MEM_WORDS];
    obi_resp_t     resp_in;
    obi_resp_t     resp_out;

    assign word_idx        = bus.addr[31:2];
    assign mem_idx         = bus.addr[AW+1:2];
    assign addr_lsb_unused = ^bus.addr[1:0];
    assign in_range        = word_idx < 30'(MEM_WORDS);

    // A retiring response frees its slot only once cnt_q has updated.
    assign bus.gnt = bus.req && !rst_i && (cnt_q < 3'(MAX_OUTSTANDING)) && (stall_q == 3'd0);
    assign accept  = bus.gnt;

    always_comb begin
        resp_in = '0;
        if (accept) begin
            resp_in.valid = 1'b1;
            resp_in.err   = !in_range;
            if (in_range && !bus.we) begin
                resp_in.rdata = mem_q[mem_idx];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, resp_out.valid})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = 3'(GNT_STALL);
        end else if (stall_q != 3'd0) begin
            stall_d = stall_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= 3'd0;
            stall_q <= 3'd0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && bus.we && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be[k]) begin
                    mem_q[mem_idx][8*k +: 8] <= bus.wdata[8*k +: 8];
                end
            end
        end
    end

    cv32e40p_obi_resp_pipe #(
        .RESP_LAT (RESP_LAT)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .resp_i (resp_in),
        .resp_o (resp_out)
    );

    assign bus.rvalid    = resp_out.valid;
    assign bus.rdata     = resp_out.rdata;
    assign bus.err       = resp_out.err;
    assign bus.parity    = even_parity(resp_out.rdata);
    assign outstanding_o = cnt_q;

endmodule
